// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 active-low keypad row scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'hF;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Lowest column index pulled low; only meaningful when some bit is 0.
    function automatic logic [1:0] lowest_zero(input logic [3:0] col_n);
        logic [1:0] idx;
        casez (col_n)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-clk scan strobe every SCAN_DIV clocks.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;

    // Divider counter, wraps to zero on the strobe cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with press/release debounce and one-clk key_valid pulse.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    // A stable tick completes debounce when the count would reach DEBOUNCE_SCANS.
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_param
        $error("keypad_scan: parameter out of range");
    end

    logic       w_tick;
    logic [3:0] r_col_n;
    state_e     r_state;
    logic [1:0] r_row;
    logic [1:0] r_col;
    logic [3:0] r_cnt;
    logic [3:0] r_row_n;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_key_down;

    logic       w_col_none;
    logic       w_col_hit;
    logic       w_deb_done;
    logic [1:0] w_row_next;
    logic [3:0] w_cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0] r_rep;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_col_none = (r_col_n == COL_NONE);
    assign w_col_hit  = ~r_col_n[r_col];
    assign w_deb_done = (r_cnt >= DEB_LAST);
    assign w_row_next = r_row + 2'd1;
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    // One-flop column sample; the FSM only ever looks at the registered copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_n <= COL_NONE;
        end else begin
            r_col_n <= col_n;
        end
    end

    // Scan / debounce FSM with registered row drive and key outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_cnt       <= 4'd0;
            r_row_n     <= ROW_IDLE;
            r_key_code  <= KEY_0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_col_none) begin
                            r_row   <= w_row_next;
                            r_row_n <= row_drive(w_row_next);
                        end else begin
                            r_col   <= lowest_zero(r_col_n);
                            r_cnt   <= 4'd1;
                            r_state <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (!w_col_hit) begin
                            r_cnt   <= 4'd0;
                            r_state <= SCAN;
                        end else if (w_deb_done) begin
                            r_key_code  <= {r_row, r_col};
                            r_key_valid <= 1'b1;
                            r_key_down  <= 1'b1;
                            r_cnt       <= 4'd0;
                            r_state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            r_rep       <= '0;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    HELD: begin
                        // Any low column keeps the key held; a second key is ignored.
                        if (w_col_none) begin
                            r_cnt   <= 4'd1;
                            r_state <= DEB_REL;
`ifdef KEYPAD_REPEAT_EN
                            r_rep   <= '0;
`endif
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (r_rep == REP_LAST) begin
                                r_rep       <= '0;
                                r_key_valid <= 1'b1;
                            end else begin
                                r_rep <= r_rep + {{(REP_W-1){1'b0}}, 1'b1};
                            end
`else
                            r_cnt <= 4'd0;
`endif
                        end
                    end
                    DEB_REL: begin
                        if (!w_col_none) begin
                            r_cnt   <= 4'd0;
                            r_state <= HELD;
                        end else if (w_deb_done) begin
                            r_key_down <= 1'b0;
                            r_cnt      <= 4'd0;
                            r_row      <= w_row_next;
                            r_row_n    <= row_drive(w_row_next);
                            r_state    <= SCAN;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed scoreboard bench for keypad_scan with a pull-down keypad model.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;
    logic [1:0]  tb_div;
    logic        prev_valid = 1'b0;
    logic [3:0]  sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    // Reference scan-tick phase: strobe on the posedge where the count is 3.
    always @(posedge clk) begin
        if (!rst_n) tb_div <= 2'd0;
        else        tb_div <= tb_div + 2'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (tb_div != 2'd3 || !rst_n);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic wait_row(input logic [3:0] want, input string tag);
        for (int i = 0; i < 8 && row_n !== want; i++) wait_tick();
        chk(tag, row_n, want);
    endtask

    task automatic wait_down(input string tag);
        for (int i = 0; i < 12 && key_down !== 1'b1; i++) wait_tick();
        chk(tag, key_down, 1'b1);
    endtask

    // Scoreboard consumer: every key_valid pulse must match a queued code.
    always @(negedge clk) begin
        if (key_valid) begin
            chk("pulse_expected", 8'(sb_q.size() > 0), 8'd1);
            if (sb_q.size() > 0) chk("pulse_code", key_code, sb_q.pop_front());
            chk("valid_not_back_to_back", prev_valid, 1'b0);
        end
        prev_valid <= key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_row;
        logic [3:0] exp_rows[4];
        int n;
        exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset values and row stepping every 4 clocks
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_down", key_down, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            prev_row = row_n;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (row_n === prev_row && n < 10);
            chk("row_step_value", row_n, exp_rows[k]);
            chk("row_step_period", 8'(n), 8'd4);
        end

        // Single press row2/col1 held 40 clk
        sb_q.push_back(4'd9);
        pressed[9] = 1'b1;
        ticks(10);
        chk("held_down", key_down, 1'b1);
        chk("held_code", key_code, 4'd9);
        pressed[9] = 1'b0;
        ticks(2);
        chk("rel_pending_down", key_down, 1'b1);
        wait_tick();
        chk("rel_done_down", key_down, 1'b0);

        // Bounce on row0/col3: 2 ticks present, 1 absent, then stable
        wait_row(4'b1110, "bounce_sync_row0");
        sb_q.push_back(4'd3);
        pressed[3] = 1'b1;
        ticks(2);
        pressed[3] = 1'b0;
        wait_tick();
        chk("bounce_gap_down", key_down, 1'b0);
        pressed[3] = 1'b1;
        ticks(2);
        chk("bounce_two_stable_down", key_down, 1'b0);
        wait_tick();
        chk("bounce_accept_down", key_down, 1'b1);
        chk("bounce_code", key_code, 4'd3);
        pressed[3] = 1'b0;
        ticks(3);
        chk("bounce_rel_down", key_down, 1'b0);

        // Two keys in row1: lowest column wins; release bounce keeps HELD
        sb_q.push_back(4'd4);
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        wait_down("multi_accept");
        chk("multi_code", key_code, 4'd4);
        ticks(2);
        pressed[4] = 1'b0;
        pressed[7] = 1'b0;
        wait_tick();
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        ticks(3);
        chk("rel_bounce_down", key_down, 1'b1);
        pressed[4] = 1'b0;
        pressed[7] = 1'b0;
        ticks(3);
        chk("multi_rel_down", key_down, 1'b0);

        // Long hold row3/col3 for 30 ticks
        wait_row(4'b0111, "hold_sync_row3");
        sb_q.push_back(4'd15);
`ifdef KEYPAD_REPEAT_EN
        for (int k = 0; k < 3; k++) sb_q.push_back(4'd15);
`endif
        pressed[15] = 1'b1;
        ticks(30);
        chk("long_hold_down", key_down, 1'b1);
        chk("long_hold_code", key_code, 4'd15);
        pressed[15] = 1'b0;
        ticks(3);
        chk("long_rel_down", key_down, 1'b0);

        // Reset while HELD, then re-acceptance of the still-held key
        sb_q.push_back(4'd9);
        pressed[9] = 1'b1;
        wait_down("pre_reset_accept");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_row_n", row_n, 4'b1110);
        chk("midrst_key_down", key_down, 1'b0);
        chk("midrst_key_valid", key_valid, 1'b0);
        chk("midrst_key_code", key_code, 4'h0);
        rst_n = 1'b1;
        sb_q.push_back(4'd9);
        wait_down("reaccept_down");
        chk("reaccept_code", key_code, 4'd9);
        pressed[9] = 1'b0;
        ticks(3);
        chk("reaccept_rel_down", key_down, 1'b0);

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
